// File: rtl/id_stage_pipe_if.sv
// Handshake and data bundle between fetch, write-back and execute around the
// decode stage. The environment side uses master and the decode stage uses slave.
interface id_stage_pipe_if #(
    parameter int DATA_W = 32
) ();
    // Fetch side
    logic              if_valid;
    logic              if_ready;
    logic [31:0]       if_instr;
    logic [31:0]       if_pc;
    // Write-back port
    logic              wb_en;
    logic [3:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    // Pipeline control
    logic              flush;
    // Execute side
    logic              ex_valid;
    logic              ex_ready;
    logic [2:0]        ex_type;
    logic [4:0]        ex_op;
    logic [3:0]        ex_wc;
    logic              ex_wr;
    logic [DATA_W-1:0] ex_pra;
    logic [DATA_W-1:0] ex_prb;
    logic [DATA_W-1:0] ex_imm;
    logic [31:0]       ex_pc;

    modport master (
        output if_valid, if_instr, if_pc, wb_en, wb_addr, wb_data, flush, ex_ready,
        input  if_ready, ex_valid, ex_type, ex_op, ex_wc, ex_wr,
               ex_pra, ex_prb, ex_imm, ex_pc
    );

    modport slave (
        input  if_valid, if_instr, if_pc, wb_en, wb_addr, wb_data, flush, ex_ready,
        output if_ready, ex_valid, ex_type, ex_op, ex_wc, ex_wr,
               ex_pra, ex_prb, ex_imm, ex_pc
    );
endinterface

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: register bank with write-through bypass,
// immediate extension, RAW scoreboard with stall, and a valid/ready ID/EX
// output register with flush.
module id_stage_pipe #(
    parameter int         DATA_W       = 32,
    parameter int         NUM_REGS     = 16,
    parameter bit         R0_ZERO      = 1'b1,
    parameter logic [7:0] WR_TYPE_MASK = 8'h0F,
    parameter logic [7:0] SE_TYPE_MASK = 8'h0F
) (
    input  logic           CLK,
    input  logic           RST,
    id_stage_pipe_if.slave bus
);
    // Instruction fields; the immediate overlaps RB.
    logic [2:0]  w_type;
    logic [4:0]  w_op;
    logic [3:0]  w_wc;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [15:0] w_imm16;

    assign w_type  = bus.if_instr[31:29];
    assign w_op    = bus.if_instr[28:24];
    assign w_wc    = bus.if_instr[23:20];
    assign w_ra    = bus.if_instr[19:16];
    assign w_rb    = bus.if_instr[15:12];
    assign w_imm16 = bus.if_instr[15:0];

    // Storage covers the whole 4-bit address space. Entries at or above
    // NUM_REGS (and r0 when R0_ZERO) are never written and never marked
    // pending, so they read 0 and cannot stall anything.
    logic [DATA_W-1:0] r_regs [16];
    logic [15:0]       r_sb;
    logic [15:0]       w_sb_next;

    // ID/EX register
    logic              r_ex_valid;
    logic [2:0]        r_ex_type;
    logic [4:0]        r_ex_op;
    logic [3:0]        r_ex_wc;
    logic              r_ex_wr;
    logic [DATA_W-1:0] r_ex_pra;
    logic [DATA_W-1:0] r_ex_prb;
    logic [DATA_W-1:0] r_ex_imm;
    logic [31:0]       r_ex_pc;

    // A write-back only lands when it targets a real, writable register.
    logic w_wb_ok;
    assign w_wb_ok = bus.wb_en && (int'(bus.wb_addr) < NUM_REGS)
                     && !(R0_ZERO && bus.wb_addr == 4'd0);

    // Operand reads with write-through bypass from the write-back port.
    logic [DATA_W-1:0] w_pra;
    logic [DATA_W-1:0] w_prb;
    assign w_pra = (w_wb_ok && bus.wb_addr == w_ra) ? bus.wb_data : r_regs[w_ra];
    assign w_prb = (w_wb_ok && bus.wb_addr == w_rb) ? bus.wb_data : r_regs[w_rb];

    // Immediate extension and writes-WC flag.
    logic [DATA_W-1:0] w_imm;
    logic              w_wr;
    assign w_imm = SE_TYPE_MASK[w_type] ? DATA_W'($signed(w_imm16)) : DATA_W'(w_imm16);
    assign w_wr  = WR_TYPE_MASK[w_type] && !(R0_ZERO && w_wc == 4'd0);

    // RAW hazard: the source is pending on the scoreboard (unless being written
    // back right now) or is the destination of the instruction sitting in EX.
    // r0 under R0_ZERO is covered implicitly: its bit is never set and ex_wr is
    // forced low for WC=0.
    logic w_ra_hz;
    logic w_rb_hz;
    logic w_hazard;
    assign w_ra_hz  = (r_sb[w_ra] && !(bus.wb_en && bus.wb_addr == w_ra))
                      || (r_ex_valid && r_ex_wr && r_ex_wc == w_ra);
    assign w_rb_hz  = (r_sb[w_rb] && !(bus.wb_en && bus.wb_addr == w_rb))
                      || (r_ex_valid && r_ex_wr && r_ex_wc == w_rb);
    assign w_hazard = w_ra_hz || w_rb_hz;

    // Handshake
    logic w_slot_free;
    logic w_if_ready;
    logic w_accept;
    logic w_leave;
    assign w_slot_free = !r_ex_valid || bus.ex_ready;
    assign w_if_ready  = w_slot_free && !w_hazard && !bus.flush && !RST;
    assign w_accept    = bus.if_valid && w_if_ready;
    assign w_leave     = r_ex_valid && bus.ex_ready && !bus.flush;

    // Scoreboard update: clear on write-back first, then set on hand-off so a
    // same-register collision leaves the bit set.
    // NOTE: start from a full default so no path leaves w_sb_next unassigned (no latch).
    always_comb begin
        w_sb_next = r_sb;
        if (bus.wb_en) begin
            w_sb_next[bus.wb_addr] = 1'b0;
        end
        if (w_leave && r_ex_wr && int'(r_ex_wc) < NUM_REGS) begin
            w_sb_next[r_ex_wc] = 1'b1;
        end
    end

    // Register bank and scoreboard state.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the bank is reset because the architecture defines every register as 0 after reset.
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= '0;
            end
            r_sb <= '0;
        end else begin
            if (w_wb_ok) begin
                r_regs[bus.wb_addr] <= bus.wb_data;
            end
            r_sb <= w_sb_next;
        end
    end

    // ID/EX register: load on accept, bubble when free but idle, hold when stalled.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ex_valid <= 1'b0;
            r_ex_type  <= '0;
            r_ex_op    <= '0;
            r_ex_wc    <= '0;
            r_ex_wr    <= 1'b0;
            r_ex_pra   <= '0;
            r_ex_prb   <= '0;
            r_ex_imm   <= '0;
            r_ex_pc    <= '0;
        end else if (bus.flush) begin
            r_ex_valid <= 1'b0;
        end else if (w_slot_free) begin
            r_ex_valid <= w_accept;
            if (w_accept) begin
                r_ex_type <= w_type;
                r_ex_op   <= w_op;
                r_ex_wc   <= w_wc;
                r_ex_wr   <= w_wr;
                r_ex_pra  <= w_pra;
                r_ex_prb  <= w_prb;
                r_ex_imm  <= w_imm;
                r_ex_pc   <= bus.if_pc;
            end
        end
    end

    assign bus.if_ready = w_if_ready;
    assign bus.ex_valid = r_ex_valid;
    assign bus.ex_type  = r_ex_type;
    assign bus.ex_op    = r_ex_op;
    assign bus.ex_wc    = r_ex_wc;
    assign bus.ex_wr    = r_ex_wr;
    assign bus.ex_pra   = r_ex_pra;
    assign bus.ex_prb   = r_ex_prb;
    assign bus.ex_imm   = r_ex_imm;
    assign bus.ex_pc    = r_ex_pc;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: a decode table, directed corner
// sequences and a randomized run against a behavioural model.
module tb_id_stage_pipe;
    localparam int         DATA_W       = 32;
    localparam int         NUM_REGS     = 16;
    localparam bit         R0_ZERO      = 1'b1;
    localparam logic [7:0] WR_TYPE_MASK = 8'h0F;
    localparam logic [7:0] SE_TYPE_MASK = 8'h0F;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_stage_pipe_if #(.DATA_W(DATA_W)) bus ();

    id_stage_pipe #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .R0_ZERO(R0_ZERO),
        .WR_TYPE_MASK(WR_TYPE_MASK), .SE_TYPE_MASK(SE_TYPE_MASK)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] t, input logic [4:0] op,
                                       input logic [3:0] wc, input logic [3:0] ra,
                                       input logic [15:0] imm);
        return {t, op, wc, ra, imm};
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        logic              valid;
        logic [2:0]        typ;
        logic [4:0]        op;
        logic [3:0]        wc;
        logic              wr;
        logic [DATA_W-1:0] pra;
        logic [DATA_W-1:0] prb;
        logic [DATA_W-1:0] imm;
        logic [31:0]       pc;
    } ex_t;

    logic [DATA_W-1:0] m_rf [16];
    bit                m_pend [16];
    ex_t               m_ex;

    function automatic bool_writable(input logic [3:0] a);
        return (int'(a) < NUM_REGS) && !(R0_ZERO && a == 4'd0);
    endfunction

    function automatic logic [DATA_W-1:0] m_read(input logic [3:0] a);
        if (!bool_writable(a)) return '0;
        if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
        return m_rf[a];
    endfunction

    function automatic logic m_src_blocked(input logic [3:0] r);
        if (R0_ZERO && r == 4'd0) return 1'b0;
        if (m_pend[r] && !(bus.wb_en && bus.wb_addr == r)) return 1'b1;
        return m_ex.valid && m_ex.wr && m_ex.wc == r;
    endfunction

    function automatic logic m_ready();
        logic [3:0] ra, rb;
        ra = bus.if_instr[19:16];
        rb = bus.if_instr[15:12];
        return (!m_ex.valid || bus.ex_ready) && !m_src_blocked(ra) && !m_src_blocked(rb)
               && !bus.flush && !rst;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic m_step();
        ex_t        nxt;
        logic       acc, free, leaving;
        logic [2:0] t;
        logic [15:0] im;
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_rf[i]   = '0;
                m_pend[i] = 1'b0;
            end
            m_ex = '{default: '0};
            return;
        end
        acc     = bus.if_valid && m_ready();
        free    = !m_ex.valid || bus.ex_ready;
        leaving = m_ex.valid && bus.ex_ready && !bus.flush;
        t       = bus.if_instr[31:29];
        im      = bus.if_instr[15:0];
        nxt.valid = 1'b1;
        nxt.typ   = t;
        nxt.op    = bus.if_instr[28:24];
        nxt.wc    = bus.if_instr[23:20];
        nxt.wr    = WR_TYPE_MASK[t] && !(R0_ZERO && nxt.wc == 4'd0);
        nxt.pra   = m_read(bus.if_instr[19:16]);
        nxt.prb   = m_read(bus.if_instr[15:12]);
        nxt.imm   = SE_TYPE_MASK[t] ? {{(DATA_W-16){im[15]}}, im} : {{(DATA_W-16){1'b0}}, im};
        nxt.pc    = bus.if_pc;
        if (bus.wb_en) m_pend[bus.wb_addr] = 1'b0;
        if (leaving && m_ex.wr && int'(m_ex.wc) < NUM_REGS) m_pend[m_ex.wc] = 1'b1;
        if (bus.wb_en && bool_writable(bus.wb_addr)) m_rf[bus.wb_addr] = bus.wb_data;
        if (bus.flush) m_ex.valid = 1'b0;
        else if (acc) m_ex = nxt;
        else if (free) m_ex.valid = 1'b0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic er, input logic fl, input logic we,
                         input logic [3:0] wa, input logic [31:0] wd);
        bus.if_valid = v;
        bus.if_instr = instr;
        bus.if_pc    = pc;
        bus.ex_ready = er;
        bus.flush    = fl;
        bus.wb_en    = we;
        bus.wb_addr  = wa;
        bus.wb_data  = wd;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
    endtask

    // Let inputs settle and compare the combinational ready against the model.
    task automatic settle();
        #1;
        check("if_ready", bus.if_ready, m_ready());
    endtask

    // Clock once, advance the model, compare the ID/EX register.
    task automatic clk_edge();
        @(posedge clk);
        m_step();
        #1;
        check("ex_valid", bus.ex_valid, m_ex.valid);
        if (m_ex.valid) begin
            check("ex_type", bus.ex_type, m_ex.typ);
            check("ex_op",   bus.ex_op,   m_ex.op);
            check("ex_wc",   bus.ex_wc,   m_ex.wc);
            check("ex_wr",   bus.ex_wr,   m_ex.wr);
            check("ex_pra",  bus.ex_pra,  m_ex.pra);
            check("ex_prb",  bus.ex_prb,  m_ex.prb);
            check("ex_imm",  bus.ex_imm,  m_ex.imm);
            check("ex_pc",   bus.ex_pc,   m_ex.pc);
        end
    endtask

    task automatic tick();
        settle();
        clk_edge();
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  typ;
        logic [4:0]  op;
        logic [3:0]  wc;
        logic        wr;
        logic [31:0] pra;
        logic [31:0] prb;
        logic [31:0] imm;
    } vec_t;

    vec_t tbl [6];

    initial begin
        // Registers are preloaded with r_i = i * 0x01010101 before the table runs.
        tbl[0] = '{mk(3'd0, 5'd1,  4'd0,  4'd1,  16'h8001), 3'd0, 5'd1,  4'd0,  1'b0, 32'h01010101, 32'h08080808, 32'hFFFF8001};
        tbl[1] = '{mk(3'd4, 5'd2,  4'd5,  4'd3,  16'h8001), 3'd4, 5'd2,  4'd5,  1'b0, 32'h03030303, 32'h08080808, 32'h00008001};
        tbl[2] = '{mk(3'd7, 5'd16, 4'd2,  4'd14, 16'hC0DE), 3'd7, 5'd16, 4'd2,  1'b0, 32'h0E0E0E0E, 32'h0C0C0C0C, 32'h0000C0DE};
        tbl[3] = '{mk(3'd1, 5'd5,  4'd0,  4'd2,  16'hFFFF), 3'd1, 5'd5,  4'd0,  1'b0, 32'h02020202, 32'h0F0F0F0F, 32'hFFFFFFFF};
        tbl[4] = '{mk(3'd3, 5'd31, 4'd15, 4'd0,  16'h7FFF), 3'd3, 5'd31, 4'd15, 1'b1, 32'h00000000, 32'h07070707, 32'h00007FFF};
        tbl[5] = '{mk(3'd2, 5'd9,  4'd10, 4'd6,  16'h3456), 3'd2, 5'd9,  4'd10, 1'b1, 32'h06060606, 32'h03030303, 32'h00003456};

        m_ex = '{default: '0};
        for (int i = 0; i < 16; i++) begin
            m_rf[i]   = '0;
            m_pend[i] = 1'b0;
        end

        // Reset: fetch offered but never accepted, ID/EX cleared.
        rst = 1'b1;
        drive(1'b1, mk(3'd0, 5'd1, 4'd1, 4'd1, 16'h0), 32'h40, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
        settle();
        check("rst_if_ready", bus.if_ready, 1'b0);
        clk_edge();
        tick();
        check("rst_ex_valid", bus.ex_valid, 1'b0);
        check("rst_ex_pc",    bus.ex_pc,    32'h0);
        check("rst_ex_pra",   bus.ex_pra,   32'h0);
        check("rst_ex_imm",   bus.ex_imm,   32'h0);
        rst = 1'b0;

        // Basic issue with sign-extended immediate.
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 4'd3, 32'h1234);
        tick();
        drive(1'b1, mk(3'd0, 5'd0, 4'd0, 4'd3, 16'h8001), 32'h80, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
        tick();
        check("a_ex_valid", bus.ex_valid, 1'b1);
        check("a_ex_pra",   bus.ex_pra,   32'h1234);
        check("a_ex_imm",   bus.ex_imm,   32'hFFFF8001);

        // Preload r_i = i * 0x01010101.
        for (int i = 1; i < 16; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 4'(i), 32'(i) * 32'h01010101);
            tick();
        end
        idle();
        tick();

        // Decode table: one instruction then a bubble each.
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, tbl[k].instr, 32'h100 + 32'(4 * k), 1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
            settle();
            check("tbl_if_ready", bus.if_ready, 1'b1);
            clk_edge();
            check("tbl_ex_valid", bus.ex_valid, 1'b1);
            check("tbl_ex_type",  bus.ex_type,  tbl[k].typ);
            check("tbl_ex_op",    bus.ex_op,    tbl[k].op);
            check("tbl_ex_wc",    bus.ex_wc,    tbl[k].wc);
            check("tbl_ex_wr",    bus.ex_wr,    tbl[k].wr);
            check("tbl_ex_pra",   bus.ex_pra,   tbl[k].pra);
            check("tbl_ex_prb",   bus.ex_prb,   tbl[k].prb);
            check("tbl_ex_imm",   bus.ex_imm,   tbl[k].imm);
            check("tbl_ex_pc",    bus.ex_pc,    32'h100 + 32'(4 * k));
            idle();
            tick();
        end

        // RAW stall on r5, released by write-back with bypass.
        drive(1'b1, mk(3'd0, 5'd1, 4'd5, 4'd1, 16'h0), 32'h200, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
        tick();
        drive(1'b1, mk(3'd4, 5'd0, 4'd0, 4'd5, 16'h0), 32'h204, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
        settle();
        check("raw_stall_ex", bus.if_ready, 1'b0);
        clk_edge();
        settle();
        check("raw_stall_sb", bus.if_ready, 1'b0);
        clk_edge();
        drive(1'b1, mk(3'd4, 5'd0, 4'd0, 4'd5, 16'h0), 32'h204, 1'b1, 1'b0, 1'b1, 4'd5, 32'hAA);
        settle();
        check("raw_release", bus.if_ready, 1'b1);
        clk_edge();
        check("raw_bypass_pra", bus.ex_pra, 32'hAA);
        check("raw_ex_pc",      bus.ex_pc,  32'h204);
        idle();
        tick();

        // Back-pressure: ex_* hold while ex_ready=0.
        drive(1'b1, mk(3'd5, 5'd3, 4'd0, 4'd4, 16'h1111), 32'h300, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, mk(3'd6, 5'd7, 4'd0, 4'd2, 16'h2222), 32'h304, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
            settle();
            check("bp_if_ready", bus.if_ready, 1'b0);
            clk_edge();
            check("bp_ex_valid", bus.ex_valid, 1'b1);
            check("bp_ex_pc",    bus.ex_pc,    32'h300);
            check("bp_ex_op",    bus.ex_op,    5'd3);
        end
        drive(1'b1, mk(3'd6, 5'd7, 4'd0, 4'd2, 16'h2222), 32'h304, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
        settle();
        check("bp_release", bus.if_ready, 1'b1);
        clk_edge();
        check("bp_next_pc", bus.ex_pc, 32'h304);
        idle();
        tick();

        // Flush a stalled writer to r7; a reader of r7 then issues freely.
        drive(1'b1, mk(3'd0, 5'd1, 4'd7, 4'd1, 16'h0), 32'h400, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        tick();
        check("fl_ex_wr", bus.ex_wr, 1'b1);
        drive(1'b1, mk(3'd4, 5'd0, 4'd0, 4'd7, 16'h0), 32'h404, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
        settle();
        check("fl_if_ready", bus.if_ready, 1'b0);
        clk_edge();
        check("fl_ex_valid", bus.ex_valid, 1'b0);
        drive(1'b1, mk(3'd4, 5'd0, 4'd0, 4'd7, 16'h0), 32'h404, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
        settle();
        check("fl_no_stall", bus.if_ready, 1'b1);
        clk_edge();
        check("fl_reader_pra", bus.ex_pra, 32'h07070707);
        idle();
        tick();

        // r0 is hard-wired zero and never a hazard source.
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 4'd0, 32'hFF);
        tick();
        drive(1'b1, mk(3'd4, 5'd0, 4'd0, 4'd0, 16'h0), 32'h500, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
        tick();
        check("r0_pra", bus.ex_pra, 32'h0);
        drive(1'b1, mk(3'd0, 5'd2, 4'd0, 4'd1, 16'h0), 32'h504, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
        tick();
        check("r0_wr", bus.ex_wr, 1'b0);
        drive(1'b1, mk(3'd4, 5'd1, 4'd0, 4'd0, 16'h0), 32'h508, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
        settle();
        check("r0_no_stall", bus.if_ready, 1'b1);
        clk_edge();
        idle();
        tick();

        // Scoreboard set and clear on r2 in the same cycle: set wins.
        drive(1'b1, mk(3'd0, 5'd1, 4'd2, 4'd1, 16'h0), 32'h600, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
        tick();
        drive(1'b1, mk(3'd0, 5'd2, 4'd2, 4'd1, 16'h0), 32'h604, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
        settle();
        check("sc_w2_ready", bus.if_ready, 1'b1);
        clk_edge();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 4'd2, 32'h55);
        tick();
        drive(1'b1, mk(3'd4, 5'd0, 4'd0, 4'd2, 16'h0), 32'h608, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
        settle();
        check("sc_set_wins", bus.if_ready, 1'b0);
        clk_edge();
        drive(1'b1, mk(3'd4, 5'd0, 4'd0, 4'd2, 16'h0), 32'h608, 1'b1, 1'b0, 1'b1, 4'd2, 32'h77);
        settle();
        check("sc_release", bus.if_ready, 1'b1);
        clk_edge();
        check("sc_bypass_pra", bus.ex_pra, 32'h77);
        idle();
        tick();

        // Reset while stalled discards the held instruction.
        drive(1'b1, mk(3'd5, 5'd4, 4'd0, 4'd1, 16'h0), 32'h700, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        tick();
        rst = 1'b1;
        drive(1'b1, mk(3'd5, 5'd5, 4'd0, 4'd1, 16'h0), 32'h704, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        settle();
        check("rs_if_ready", bus.if_ready, 1'b0);
        clk_edge();
        check("rs_ex_valid", bus.ex_valid, 1'b0);
        rst = 1'b0;
        idle();
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 3) != 0, $urandom, $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), $urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
